// File: rtl/wall_bank.sv
// rtl/wall_bank.sv - multi-wall obstacle bank: serial per-frame scroll, hole drift/reload, pass scoring
// One wall is updated per clock after a tick; position buses feed the draw and collision logic.
module wall_bank #(
  parameter int NUM_WALLS    = 2,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int SCREEN_W     = 160,
  parameter int WALL_SPACING = 80,
  parameter int WALL_SPEED   = 4,
  parameter int HOLE_MIN     = 16,
  parameter int HOLE_MAX     = 100,
  parameter int HOLE_STEP    = 4,
  parameter int BIRD_X       = 40,
  parameter int SCORE_W      = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     tick,
  input  logic                     mode,
  output logic [NUM_WALLS*X_W-1:0] wall_x_bus,
  output logic [NUM_WALLS*Y_W-1:0] hole_y_bus,
  output logic                     pass_pulse,
  output logic [SCORE_W-1:0]       score,
  output logic                     busy,
  output logic                     update_done
);

  localparam int IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_WALLS - 1);
  localparam logic [X_W:0]       SPEED_E   = (X_W+1)'(WALL_SPEED);
  localparam logic [X_W:0]       WRAP_ADD  = (X_W+1)'(SCREEN_W - WALL_SPEED);
  localparam logic [X_W:0]       BIRD_E    = (X_W+1)'(BIRD_X);
  localparam logic [Y_W:0]       HMIN_E    = (Y_W+1)'(HOLE_MIN);
  localparam logic [Y_W:0]       HMAX_E    = (Y_W+1)'(HOLE_MAX);
  localparam logic [Y_W:0]       STEP_E    = (Y_W+1)'(HOLE_STEP);
  localparam logic [Y_W-1:0]     HMIN_Y    = Y_W'(HOLE_MIN);
  localparam logic [Y_W-1:0]     HMAX_Y    = Y_W'(HOLE_MAX);
  localparam logic [Y_W-1:0]     HOLE_MID  = Y_W'((HOLE_MIN + HOLE_MAX) / 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           lfsr;
  logic [X_W-1:0]       wall_x [NUM_WALLS];
  logic [Y_W-1:0]       hole_y [NUM_WALLS];
  logic [NUM_WALLS-1:0] dir_up;

  logic [X_W:0]   cur_x;
  logic [Y_W:0]   cur_h;
  logic [Y_W:0]   rnd;
  logic           cur_up;
  logic           wrap;
  logic           passed;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] nh;
  logic           nup;
  logic           lfsr_fb;

  function automatic logic [X_W-1:0] reset_x(input int i);
    return X_W'(SCREEN_W - 1 - (NUM_WALLS - 1 - i) * WALL_SPACING);
  endfunction

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Next state of the wall selected by idx; one extra bit keeps sums from overflowing.
  always_comb begin
    cur_x  = {1'b0, wall_x[idx]};
    cur_h  = {1'b0, hole_y[idx]};
    cur_up = dir_up[idx];
    rnd    = {1'b0, lfsr[Y_W-1:0]};
    wrap   = cur_x < SPEED_E;
    nx     = wrap ? X_W'(cur_x + WRAP_ADD) : X_W'(cur_x - SPEED_E);
    nh     = hole_y[idx];
    nup    = cur_up;
    passed = 1'b0;
    if (wrap) begin
      if (rnd < HMIN_E)      nh = HMIN_Y;
      else if (rnd > HMAX_E) nh = HMAX_Y;
      else                   nh = rnd[Y_W-1:0];
    end else begin
      passed = (cur_x >= BIRD_E) && ((cur_x - SPEED_E) < BIRD_E);
      if (mode) begin
        if (cur_up) begin
          if (cur_h + STEP_E >= HMAX_E) begin
            nh  = HMAX_Y;
            nup = 1'b0;
          end else begin
            nh  = Y_W'(cur_h + STEP_E);
          end
        end else begin
          if (cur_h <= HMIN_E + STEP_E) begin
            nh  = HMIN_Y;
            nup = 1'b1;
          end else begin
            nh  = Y_W'(cur_h - STEP_E);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      idx         <= '0;
      lfsr        <= LFSR_SEED;
      score       <= '0;
      pass_pulse  <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      dir_up      <= '1;
      for (int i = 0; i < NUM_WALLS; i++) begin
        wall_x[i] <= reset_x(i);
        hole_y[i] <= HOLE_MID;
      end
    end else if (clear) begin
      state       <= S_IDLE;
      idx         <= '0;
      lfsr        <= LFSR_SEED;
      score       <= '0;
      pass_pulse  <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      dir_up      <= '1;
      for (int i = 0; i < NUM_WALLS; i++) begin
        wall_x[i] <= reset_x(i);
        hole_y[i] <= HOLE_MID;
      end
    end else begin
      lfsr        <= {lfsr[6:0], lfsr_fb};
      pass_pulse  <= 1'b0;
      update_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick && enable) begin
            state <= S_UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        S_UPDATE: begin
          wall_x[idx] <= nx;
          hole_y[idx] <= nh;
          dir_up[idx] <= nup;
          if (passed) begin
            pass_pulse <= 1'b1;
            if (score != SCORE_MAX) score <= score + 1'b1;
          end
          if (idx == LAST_IDX) state <= S_DONE;
          else                 idx   <= idx + 1'b1;
        end
        S_DONE: begin
          update_done <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_WALLS; g++) begin : g_bus
    assign wall_x_bus[g*X_W +: X_W] = wall_x[g];
    assign hole_y_bus[g*Y_W +: Y_W] = hole_y[g];
  end

endmodule
